// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM state encoding, special key codes and the row/column-to-key map shared by the keypad entry path.
package keypad_pkg;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    localparam logic [3:0] KEY_BACK  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    // Nibble at index row*4+col: {1,2,3,A},{4,5,6,B},{7,8,9,C},{*,0,#,D} with *=E, #=F
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_of(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[{row, col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: converts eight packed BCD digits to binary with a x10-and-add chain.
module bcd_to_binary (
    input  logic [31:0] bcd_i,
    output logic [31:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 7; i >= 0; i--)
            bin_o = (bin_o << 3) + (bin_o << 1) + {28'd0, bcd_i[i*4 +: 4]};
    end

endmodule

// File: rtl/keypad_dec_entry.sv
// keypad_dec_entry: scans/debounces a 4x4 keypad and builds a decimal entry committed as a binary value.
// Optional auto-repeat of held digit/backspace keys is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_dec_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_LIMIT     = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int MAX_DIGITS     = 8,
    parameter int REPEAT_SCANS   = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic [3:0]  key_code,
    output logic        key_strobe,
    output logic [31:0] entry,
    output logic [3:0]  digit_count,
    output logic [31:0] value,
    output logic        valid,
    output logic        overflow
);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic [3:0]  rows_m_q, rows_s_q;
    logic [31:0] tick_cnt_q;
    logic [1:0]  state_q, state_d;
    logic [3:0]  cols_q, cols_d;
    logic [1:0]  row_q, row_d, col_q, col_d;
    logic [15:0] cnt_q, cnt_d, rep_q, rep_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        strobe_q;
    logic [31:0] bcd_q, bcd_d, vbcd_q, vbcd_d;
    logic [3:0]  dig_q, dig_d;
    logic        ovf_q, ovf_d, valid_q, valid_d;
    logic        tick, any_low, same, accept;
    logic [1:0]  pri_row, cur_col;
    logic [3:0]  held_key;

    assign tick     = tick_cnt_q == 32'(SCAN_LIMIT - 1);
    assign any_low  = rows_s_q != 4'hF;
    assign pri_row  = !rows_s_q[0] ? 2'd0 : !rows_s_q[1] ? 2'd1 : !rows_s_q[2] ? 2'd2 : 2'd3;
    assign cur_col  = !cols_q[0] ? 2'd0 : !cols_q[1] ? 2'd1 : !cols_q[2] ? 2'd2 : 2'd3;
    assign same     = any_low && pri_row == row_q;
    assign held_key = key_of(row_q, col_q);

    always_comb begin
        state_d = state_q;
        cols_d  = cols_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        accept  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    cols_d  = any_low ? cols_q : {cols_q[2:0], cols_q[3]};
                    row_d   = any_low ? pri_row : row_q;
                    col_d   = any_low ? cur_col : col_q;
                    cnt_d   = '0;
                    state_d = any_low ? ST_DEBOUNCE : ST_SCAN;
                end
                ST_DEBOUNCE: begin
                    cnt_d   = same ? cnt_q + 16'd1 : '0;
                    state_d = same ? ST_DEBOUNCE : ST_SCAN;
                    if (same && cnt_q == 16'(DEBOUNCE_SCANS - 1)) begin
                        accept  = 1'b1;
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        rep_d   = '0;
                    end
                end
                ST_HELD: begin
                    // cnt counts consecutive released ticks; rep counts held ticks for auto-repeat
                    cnt_d = any_low ? '0 : cnt_q + 16'd1;
                    rep_d = (AUTOREP && same) ? rep_q + 16'd1 : '0;
                    if (!any_low && cnt_q == 16'(DEBOUNCE_SCANS - 1)) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                    end
                    if (AUTOREP && same && held_key <= KEY_BACK && rep_q == 16'(REPEAT_SCANS - 1)) begin
                        accept = 1'b1;
                        rep_d  = 16'(REPEAT_SCANS - DEBOUNCE_SCANS);
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_comb begin
        bcd_d      = bcd_q;
        dig_d      = dig_q;
        ovf_d      = ovf_q;
        vbcd_d     = vbcd_q;
        valid_d    = 1'b0;
        key_code_d = accept ? held_key : key_code_q;
        if (accept) begin
            if (held_key <= 4'd9) begin
                if (dig_q >= 4'(MAX_DIGITS))
                    ovf_d = 1'b1;
                else if (dig_q != 4'd0 || held_key != 4'd0) begin
                    bcd_d = {bcd_q[27:0], held_key};
                    dig_d = dig_q + 4'd1;
                end
            end else if (held_key == KEY_BACK) begin
                bcd_d = bcd_q >> 4;
                dig_d = (dig_q != 4'd0) ? dig_q - 4'd1 : dig_q;
            end else if (held_key == KEY_CLEAR || held_key == KEY_ENTER) begin
                vbcd_d  = (held_key == KEY_ENTER) ? bcd_q : vbcd_q;
                valid_d = held_key == KEY_ENTER;
                bcd_d   = '0;
                dig_d   = '0;
                ovf_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_m_q   <= 4'hF;
            rows_s_q   <= 4'hF;
            tick_cnt_q <= '0;
            state_q    <= ST_SCAN;
            cols_q     <= 4'b1110;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            rep_q      <= '0;
            key_code_q <= '0;
            strobe_q   <= 1'b0;
            bcd_q      <= '0;
            dig_q      <= '0;
            ovf_q      <= 1'b0;
            vbcd_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            rows_m_q   <= rows;
            rows_s_q   <= rows_m_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 32'd1;
            state_q    <= state_d;
            cols_q     <= cols_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            key_code_q <= key_code_d;
            strobe_q   <= accept;
            bcd_q      <= bcd_d;
            dig_q      <= dig_d;
            ovf_q      <= ovf_d;
            vbcd_q     <= vbcd_d;
            valid_q    <= valid_d;
        end
    end

    bcd_to_binary u_entry_conv (.bcd_i(bcd_q),  .bin_o(entry));
    bcd_to_binary u_value_conv (.bcd_i(vbcd_q), .bin_o(value));

    assign cols        = cols_q;
    assign key_code    = key_code_q;
    assign key_strobe  = strobe_q;
    assign digit_count = dig_q;
    assign overflow    = ovf_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_keypad_dec_entry.sv
// tb_keypad_dec_entry: keypad matrix model driving keypad_dec_entry with table-driven key sequences.
module tb_keypad_dec_entry;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rows, cols, key_code, digit_count;
    logic        key_strobe, valid, overflow;
    logic [31:0] entry, value;

    int p_r = 0, p_c = 0;
    bit p_on = 1'b0;
    int n_vec = 0, n_err = 0, n_str = 0, n_val = 0;

    always #5 clk = ~clk;

    // Pressed key pulls its row low only while its column is driven low
    assign rows = (p_on && !cols[p_c]) ? ~(4'b0001 << p_r) : 4'hF;

    keypad_dec_entry #(.SCAN_LIMIT(4), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols), .key_code(key_code),
        .key_strobe(key_strobe), .entry(entry), .digit_count(digit_count),
        .value(value), .valid(valid), .overflow(overflow)
    );

    always @(negedge clk) begin
        if (key_strobe) n_str++;
        if (valid) n_val++;
    end

    typedef struct {
        logic [3:0]  key;
        logic [31:0] ent;
        logic [3:0]  cnt;
        logic        ovf;
        logic [31:0] val;
    } vec_t;

    vec_t tbl[24];
    logic [3:0] km[4][4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        int t = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (km[r][c] == k) begin
                    p_r = r;
                    p_c = c;
                end
        p_on = 1'b1;
        while (key_strobe !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("strobe_seen", {31'd0, key_strobe}, 32'd1);
    endtask

    task automatic release_key(input int hold);
        repeat (hold) @(negedge clk);
        p_on = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_cols(input logic [3:0] c);
        int t = 0;
        while (cols !== c && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_cols", {28'd0, cols}, {28'd0, c});
    endtask

    initial begin
        int s0, v0;
        km = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
               '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'hE, 4'h0, 4'hF, 4'hD}};
        tbl[0]  = '{4'hE, 32'd0,        4'd0, 1'b0, 32'd0};
        tbl[1]  = '{4'h1, 32'd1,        4'd1, 1'b0, 32'd0};
        tbl[2]  = '{4'h2, 32'd12,       4'd2, 1'b0, 32'd0};
        tbl[3]  = '{4'h3, 32'd123,      4'd3, 1'b0, 32'd0};
        tbl[4]  = '{4'h4, 32'd1234,     4'd4, 1'b0, 32'd0};
        tbl[5]  = '{4'h5, 32'd12345,    4'd5, 1'b0, 32'd0};
        tbl[6]  = '{4'h6, 32'd123456,   4'd6, 1'b0, 32'd0};
        tbl[7]  = '{4'h7, 32'd1234567,  4'd7, 1'b0, 32'd0};
        tbl[8]  = '{4'h8, 32'd12345678, 4'd8, 1'b0, 32'd0};
        tbl[9]  = '{4'hF, 32'd0,        4'd0, 1'b0, 32'h00BC614E};
        tbl[10] = '{4'h9, 32'd9,        4'd1, 1'b0, 32'h00BC614E};
        tbl[11] = '{4'h9, 32'd99,       4'd2, 1'b0, 32'h00BC614E};
        tbl[12] = '{4'h9, 32'd999,      4'd3, 1'b0, 32'h00BC614E};
        tbl[13] = '{4'h9, 32'd9999,     4'd4, 1'b0, 32'h00BC614E};
        tbl[14] = '{4'h9, 32'd99999,    4'd5, 1'b0, 32'h00BC614E};
        tbl[15] = '{4'h9, 32'd999999,   4'd6, 1'b0, 32'h00BC614E};
        tbl[16] = '{4'h9, 32'd9999999,  4'd7, 1'b0, 32'h00BC614E};
        tbl[17] = '{4'h9, 32'd99999999, 4'd8, 1'b0, 32'h00BC614E};
        tbl[18] = '{4'h5, 32'd99999999, 4'd8, 1'b1, 32'h00BC614E};
        tbl[19] = '{4'hA, 32'd9999999,  4'd7, 1'b1, 32'h00BC614E};
        tbl[20] = '{4'hE, 32'd0,        4'd0, 1'b0, 32'h00BC614E};
        tbl[21] = '{4'h0, 32'd0,        4'd0, 1'b0, 32'h00BC614E};
        tbl[22] = '{4'h0, 32'd0,        4'd0, 1'b0, 32'h00BC614E};
        tbl[23] = '{4'h7, 32'd7,        4'd1, 1'b0, 32'h00BC614E};

        repeat (3) @(negedge clk);
        chk("rst_cols", {28'd0, cols}, 32'hE);
        chk("rst_key_code", {28'd0, key_code}, 32'd0);
        chk("rst_strobe", {31'd0, key_strobe}, 32'd0);
        chk("rst_entry", entry, 32'd0);
        chk("rst_count", {28'd0, digit_count}, 32'd0);
        chk("rst_value", value, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;

        // Idle scan: one column step per tick, 4 clocks apart
        wait_cols(4'hD);
        repeat (4) @(negedge clk);
        chk("idle_cols_b", {28'd0, cols}, 32'hB);
        repeat (4) @(negedge clk);
        chk("idle_cols_7", {28'd0, cols}, 32'h7);
        repeat (4) @(negedge clk);
        chk("idle_cols_e", {28'd0, cols}, 32'hE);
        chk("idle_strobes", 32'(n_str), 32'd0);
        chk("idle_entry", entry, 32'd0);

        // '4' with a one-tick bounce before settling
        s0 = n_str;
        p_r = 1; p_c = 0; p_on = 1'b1;
        repeat (6) @(negedge clk);
        p_on = 1'b0;
        repeat (4) @(negedge clk);
        press(4'h4);
        chk("bounce_code", {28'd0, key_code}, 32'd4);
        chk("bounce_entry", entry, 32'd4);
        chk("bounce_count", {28'd0, digit_count}, 32'd1);
        release_key(8);
        chk("bounce_strobes", 32'(n_str - s0), 32'd1);

        for (int i = 0; i < 24; i++) begin
            s0 = n_str;
            v0 = n_val;
            press(tbl[i].key);
            chk($sformatf("v%0d_code", i), {28'd0, key_code}, {28'd0, tbl[i].key});
            chk($sformatf("v%0d_entry_at_strobe", i), entry, tbl[i].ent);
            release_key(8);
            chk($sformatf("v%0d_entry", i), entry, tbl[i].ent);
            chk($sformatf("v%0d_count", i), {28'd0, digit_count}, {28'd0, tbl[i].cnt});
            chk($sformatf("v%0d_overflow", i), {31'd0, overflow}, {31'd0, tbl[i].ovf});
            chk($sformatf("v%0d_value", i), value, tbl[i].val);
            chk($sformatf("v%0d_strobes", i), 32'(n_str - s0), 32'd1);
            chk($sformatf("v%0d_valids", i), 32'(n_val - v0), (tbl[i].key == 4'hF) ? 32'd1 : 32'd0);
        end

        // Reset while '5' is in DEBOUNCE, key still held afterwards
        wait_cols(4'hD);
        p_r = 1; p_c = 1; p_on = 1'b1;
        repeat (6) @(negedge clk);
        s0 = n_str;
        reset = 1'b1;
        #1;
        chk("mid_rst_cols", {28'd0, cols}, 32'hE);
        chk("mid_rst_key_code", {28'd0, key_code}, 32'd0);
        chk("mid_rst_entry", entry, 32'd0);
        chk("mid_rst_count", {28'd0, digit_count}, 32'd0);
        chk("mid_rst_value", value, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_strobe", 32'(n_str - s0), 32'd0);
        reset = 1'b0;
        press(4'h5);
        chk("redetect_code", {28'd0, key_code}, 32'd5);
        chk("redetect_entry", entry, 32'd5);
        release_key(8);

        // Long hold of '3'
        press(4'hE);
        release_key(8);
        s0 = n_str;
        press(4'h3);
        release_key(240);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("hold_repeats", {31'd0, (n_str - s0) > 1}, 32'd1);
`else
        chk("hold_strobes", 32'(n_str - s0), 32'd1);
        chk("hold_entry", entry, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
